// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage behind the ALU's bitwise logic units (AND/OR/XOR).
// Each accepted result word is stored together with its opcode tag and three
// flags (zero, negative, parity). The flags are computed once, from the
// incoming word, at the moment it is captured. Entries sit in a small FIFO and
// are handed to register-file writeback over a valid/ready handshake, so a
// stalled consumer never loses a result.
//
// Parameters
//   WIDTH       data word width in bits (>= 2)
//   DEPTH       FIFO entries, power of two (>= 2)
//
// Ports
//   clk         sole clock; every state update happens on its rising edge
//   rst_n       asynchronous, active-low reset
//   in_valid    producer offers in_result/in_op this cycle
//   in_ready    stage can accept an entry this cycle (registered state only)
//   in_result   result word from the logic unit
//   in_op       opcode tag of the producing unit (opaque, passed through)
//   out_valid   head entry is valid
//   out_ready   consumer takes the head entry this cycle
//   out_result  head result word
//   out_op      head opcode tag
//   out_zero    head result == 0
//   out_neg     head result MSB
//   out_parity  XOR-reduce of head result (1 = odd number of ones)
//   res_count   entries delivered since reset, wraps 0xFFFF -> 0x0000
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [15:0]      res_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] resultMem_q [DEPTH];
    logic [2:0]       opMem_q     [DEPTH];
    logic [DEPTH-1:0] zeroMem_q;
    logic [DEPTH-1:0] negMem_q;
    logic [DEPTH-1:0] parityMem_q;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [15:0]      resCount_q, resCount_d;

    logic pushEn;
    logic popEn;

    // Both handshake qualifiers depend only on the occupancy register, so
    // there is no combinational path from out_ready back to in_ready. A full
    // stage therefore refuses a push even when the head is popped that cycle.
    assign in_ready  = (occ_q != FULL_CNT);
    assign out_valid = (occ_q != '0);
    assign pushEn    = in_valid && in_ready;
    assign popEn     = out_valid && out_ready;

    // Next-state for pointers, occupancy and delivered-result counter.
    // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        occ_d      = occ_q;
        resCount_d = resCount_q;

        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end

        if (popEn) begin
            rdPtr_d    = rdPtr_q + PTR_W'(1);
            resCount_d = resCount_q + 16'd1;
        end

        case ({pushEn, popEn})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
            resCount_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            occ_q      <= occ_d;
            resCount_q <= resCount_d;
        end
    end

    // Entry storage. The zero flag of every slot resets to 1 so the flag stays
    // consistent with the all-zero result word that slot holds after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                resultMem_q[i] <= '0;
                opMem_q[i]     <= '0;
            end
            zeroMem_q   <= '1;
            negMem_q    <= '0;
            parityMem_q <= '0;
        end else if (pushEn) begin
            resultMem_q[wrPtr_q] <= in_result;
            opMem_q[wrPtr_q]     <= in_op;
            zeroMem_q[wrPtr_q]   <= (in_result == '0);
            negMem_q[wrPtr_q]    <= in_result[WIDTH-1];
            parityMem_q[wrPtr_q] <= ^in_result;
        end
    end

    // Head of the FIFO is always presented; contents only change on a push to
    // a different slot or a pop, so a stalled head holds stable.
    assign out_result = resultMem_q[rdPtr_q];
    assign out_op     = opMem_q[rdPtr_q];
    assign out_zero   = zeroMem_q[rdPtr_q];
    assign out_neg    = negMem_q[rdPtr_q];
    assign out_parity = parityMem_q[rdPtr_q];
    assign res_count  = resCount_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Scoreboard bench for alu_result_stage. Every accepted push appends the
// {op, result} pair to a queue; every pop takes the oldest pair and the test
// task compares the DUT head (result, op, zero, neg, parity) against values
// derived from that pair. res_count is tracked independently.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_op;
    logic        out_zero;
    logic        out_neg;
    logic        out_parity;
    logic [15:0] res_count;

    int vectors = 0;
    int errors  = 0;

    logic [18:0] expQ[$];
    logic [18:0] expHead;
    logic [15:0] expCount;

    logic        obsReady;
    logic        obsValid;
    logic [21:0] obsWord;

    alu_result_stage #(
        .WIDTH(16),
        .DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_parity(out_parity),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    // Expected head word for a stored {op, result}: result, op, zero, neg, parity.
    function automatic logic [21:0] expWord(input logic [18:0] e);
        logic [15:0] r;
        r = e[15:0];
        return {r, e[18:16], (r == 16'h0000), r[15], ^r};
    endfunction

    // Drive one cycle: inputs change on the falling edge, outputs are sampled
    // there too, and the scoreboard follows the handshakes that will complete
    // at the next rising edge.
    task automatic driveCycle(input logic v, input logic [15:0] r, input logic [2:0] op,
                              input logic rdy, output logic pushed, output logic popped);
        @(negedge clk);
        in_valid  = v;
        in_result = r;
        in_op     = op;
        out_ready = rdy;
        #1;
        obsReady = in_ready;
        obsValid = out_valid;
        obsWord  = {out_result, out_op, out_zero, out_neg, out_parity};
        pushed   = v && in_ready;
        popped   = out_valid && rdy;
        if (popped) begin
            expHead  = (expQ.size() > 0) ? expQ.pop_front() : 19'h7FFFF;
            expCount = expCount + 16'd1;
        end
        if (pushed) expQ.push_back({op, r});
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_op     = '0;
        out_ready = 1'b0;
        expCount  = '0;
        expQ.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready, res_count, out_zero, out_neg, out_parity, out_result, out_op}
            !== {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b r=%b cnt=%h z=%b n=%b p=%b res=%h op=%b want v=0 r=1 cnt=0000 z=1 n=0 p=0 res=0000 op=000",
                     out_valid, in_ready, res_count, out_zero, out_neg, out_parity, out_result, out_op);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_push();
        logic pu, po;
        driveCycle(1'b1, 16'hF0F0 & 16'h0FF0, 3'b001, 1'b1, pu, po);
        vectors++;
        if (pu !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_accept: got %b want 1", pu);
        end
        driveCycle(1'b0, 16'h0000, 3'b000, 1'b1, pu, po);
        vectors++;
        if (obsValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency: out_valid got %b want 1", obsValid);
        end
        if (po) begin
            vectors++;
            if (obsWord !== expWord(expHead) || obsWord !== {16'h00F0, 3'b001, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL single_data: got %h want %h", obsWord, {16'h00F0, 3'b001, 3'b000});
            end
        end
        #1;
        vectors++;
        if (res_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d want 1", res_count);
        end
    endtask

    task automatic test_flags();
        logic [15:0] words [4];
        logic [2:0]  flagsWant [3];
        logic pu, po;
        int   k;
        words[0] = 16'h0000; words[1] = 16'h8000; words[2] = 16'h0007; words[3] = 16'h0000;
        flagsWant[0] = 3'b100; flagsWant[1] = 3'b011; flagsWant[2] = 3'b001;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            driveCycle(i < 3, words[i], 3'(i + 2), 1'b1, pu, po);
            if (po) begin
                vectors++;
                if (obsWord !== expWord(expHead) || obsWord[2:0] !== flagsWant[k]) begin
                    errors++;
                    $display("[TB] FAIL flags_%0d: got %h want %h", k, obsWord, expWord(expHead));
                end
                k++;
            end
        end
        vectors++;
        if (k !== 3) begin
            errors++;
            $display("[TB] FAIL flags_count: got %0d pops want 3", k);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] want [3];
        logic pu, po;
        int   k;
        want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333;
        k = 0;
        driveCycle(1'b1, 16'h1111, 3'b010, 1'b0, pu, po);
        driveCycle(1'b1, 16'h2222, 3'b011, 1'b0, pu, po);
        for (int i = 0; i < 3; i++) begin
            driveCycle(1'b1, 16'h3333, 3'b100, 1'b0, pu, po);
            vectors++;
            if (obsReady !== 1'b0 || pu !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_full_hold: in_ready got %b want 0", obsReady);
            end
        end
        for (int i = 0; i < 10 && (expQ.size() > 0 || in_valid); i++) begin
            driveCycle(in_valid && !pu, 16'h3333, 3'b100, 1'b1, pu, po);
            if (po) begin
                vectors++;
                if (obsWord !== expWord(expHead) || k > 2 || obsWord[21:6] !== want[k > 2 ? 2 : k]) begin
                    errors++;
                    $display("[TB] FAIL bp_order_%0d: got %h want %h", k, obsWord, expWord(expHead));
                end
                k++;
            end
        end
        vectors++;
        if (k !== 3 || expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d pops, %0d left want 3 pops, 0 left", k, expQ.size());
        end
    endtask

    task automatic test_full_simultaneous();
        logic pu, po;
        driveCycle(1'b1, 16'hA5A5, 3'b101, 1'b0, pu, po);
        driveCycle(1'b1, 16'h5A5A, 3'b110, 1'b0, pu, po);
        driveCycle(1'b1, 16'hFFFF, 3'b111, 1'b1, pu, po);
        vectors++;
        if (obsReady !== 1'b0 || po !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_pop_only: in_ready got %b pop %b want 0 1", obsReady, po);
        end
        if (po) begin
            vectors++;
            if (obsWord !== expWord(expHead)) begin
                errors++;
                $display("[TB] FAIL full_head: got %h want %h", obsWord, expWord(expHead));
            end
        end
        driveCycle(1'b1, 16'hFFFF, 3'b111, 1'b1, pu, po);
        vectors++;
        if (obsReady !== 1'b1 || pu !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_push_next: in_ready got %b want 1", obsReady);
        end
        for (int i = 0; i < 6 && expQ.size() > 0; i++) begin
            driveCycle(1'b0, 16'h0000, 3'b000, 1'b1, pu, po);
            if (po) begin
                vectors++;
                if (obsWord !== expWord(expHead)) begin
                    errors++;
                    $display("[TB] FAIL full_drain: got %h want %h", obsWord, expWord(expHead));
                end
            end
        end
        #1;
        vectors++;
        if (res_count !== expCount || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_count: got %0d valid %b want %0d valid 0", res_count, out_valid, expCount);
        end
    endtask

    task automatic test_async_reset();
        logic pu, po;
        driveCycle(1'b1, 16'hAAAA, 3'b010, 1'b0, pu, po);
        driveCycle(1'b1, 16'hBBBB, 3'b011, 1'b0, pu, po);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready, out_zero, res_count, out_result} !== {1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b r=%b z=%b cnt=%h res=%h want v=0 r=1 z=1 cnt=0000 res=0000",
                     out_valid, in_ready, out_zero, res_count, out_result);
        end
        expQ.delete();
        expCount = '0;
        @(negedge clk);
        rst_n = 1'b1;
        driveCycle(1'b1, 16'h0F0F, 3'b101, 1'b1, pu, po);
        driveCycle(1'b0, 16'h0000, 3'b000, 1'b1, pu, po);
        vectors++;
        if (obsValid !== 1'b1 || obsWord !== expWord({3'b101, 16'h0F0F})) begin
            errors++;
            $display("[TB] FAIL async_after: got valid %b word %h want 1 %h", obsValid, obsWord, expWord({3'b101, 16'h0F0F}));
        end
    endtask

    task automatic test_streaming();
        logic        pu, po;
        logic [15:0] r;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        expQ.delete();
        expCount = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 70000; i++) begin
            r = 16'($urandom);
            driveCycle(i < 70000, r, 3'($urandom_range(0, 7)), 1'b1, pu, po);
            vectors++;
            if (obsReady !== 1'b1 || (i > 0 && po !== 1'b1)) begin
                errors++;
                if (errors < 20) $display("[TB] FAIL stream_rate_%0d: in_ready %b pop %b want 1 1", i, obsReady, po);
            end
            if (po) begin
                vectors++;
                if (obsWord !== expWord(expHead)) begin
                    errors++;
                    if (errors < 20) $display("[TB] FAIL stream_data_%0d: got %h want %h", i, obsWord, expWord(expHead));
                end
            end
        end
        #1;
        vectors++;
        if (res_count !== 16'd4464 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_wrap: got %0d valid %b want 4464 valid 0", res_count, out_valid);
        end
    endtask

    // Scenario sequence; each task leaves the stage drained or reset.
    initial begin
        test_reset();
        test_single_push();
        test_flags();
        test_backpressure();
        test_full_simultaneous();
        test_async_reset();
        test_streaming();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the 16-bit bitwise logic units (AND/OR/XOR) of the ALU. It captures each result word and the opcode that produced it, computes zero/negative/parity flags at capture time, and buffers them in a small FIFO. The FIFO presents them to the consumer (register-file writeback) over a valid/ready handshake, so a stalled consumer never loses a result.

## Interface
- WIDTH, 16, data word width in bits (≥2)
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  input  1  sole clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  producer offers in_result/in_op this cycle
- in_ready  output  1  stage can accept an entry this cycle
- in_result  input  WIDTH  result word from logic unit
- in_op  input  3  opcode tag of producing unit (opaque, passed through)
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes head entry this cycle
- out_result  output  WIDTH  head result word
- out_op  output  3  head opcode tag
- out_zero  output  1  head result == 0
- out_neg  output  1  head result MSB
- out_parity  output  1  XOR-reduce of head result (1 = odd number of ones)
- res_count  output  16  number of entries delivered since reset, wraps 0xFFFF→0x0000

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_result, in_op, zero, neg, parity} at the write pointer; flags are computed from in_result at push, never from stored data later.
- Pop: out_valid && out_ready at a rising edge advances the read pointer and increments res_count by 1.
- Occupancy counter 0..DEPTH; in_ready = (occupancy != DEPTH), driven from registered state only (no combinational path from out_ready to in_ready).
- out_valid = (occupancy != 0); out_* fields reflect the entry at the read pointer and hold stable while out_valid && !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Push and pop in the same cycle with 0 < occupancy < DEPTH: both happen, occupancy unchanged.
- Full: in_ready low; a pop in the same cycle does not allow a push until the next cycle.
- Empty: no bypass; a push makes the entry visible on out_* only after the edge.
- in_valid while !in_ready: no write; producer must hold data (standard valid/ready, producer must not drop in_valid until accepted).
- Data outputs while out_valid low are don't-care for the consumer, but must not be X after reset (storage reset to 0).

## Timing
- Reset (rst_n low, asynchronous): occupancy=0, pointers=0, storage=0, res_count=0; out_valid=0, in_ready=1, out_result=0, out_op=0, out_zero=1, out_neg=0, out_parity=0.
- Reset asserted mid-operation discards all buffered entries immediately; first accepted push after release appears with out_valid high after one edge.
- Latency: push at edge N → out_valid high, data on out_* after edge N (1 cycle).
- Throughput: 1 entry/cycle sustained when out_ready held high.
- res_count updates on the same edge as the pop.

## Test plan
- Reset: hold rst_n low, clk toggling → out_valid=0, in_ready=1, res_count=0, out_zero=1; assert rst_n low asynchronously between edges with 2 entries buffered → out_valid falls immediately, without waiting for a clock edge.
- Single push: in_result=0x00F0 (0xF0F0 AND 0x0FF0), in_op=3'b001, out_ready=1 → next cycle out_result=0x00F0, out_zero=0, out_neg=0, out_parity=0, out_op=001; after pop res_count=1.
- Flags: push 0x0000, 0x8000, 0x0007 with out_ready=1 → zero/neg/parity = 1/0/0, 0/1/1, 0/0/1 on consecutive cycles.
- Backpressure: out_ready=0, offer 0x1111, 0x2222, 0x3333 → first two accepted, in_ready=0 while 0x3333 held; raise out_ready → order 0x1111, 0x2222, 0x3333, nothing lost or duplicated.
- Full with simultaneous pop: occupancy=DEPTH, out_ready=1 and in_valid=1 → pop only this edge, push accepted next edge.
- Streaming/wrap: 70000 back-to-back pushes with out_ready=1 → one result per cycle, pointers wrap, res_count wraps to 70000−65536=4464.
